// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, pixel width and the UART
// receiver state encoding. Reused by the loader and the shrink/effects units.
package img_pkg;

  localparam int unsigned BPP    = 3;                // bytes per pixel
  localparam int unsigned HIEGHT = 30;               // image rows
  localparam int unsigned WIDTH  = 30;               // image columns
  localparam int unsigned PEXILS = HIEGHT * WIDTH;   // pixels per frame
  localparam int unsigned SZ     = 8 * BPP;          // pixel width in bits
  localparam int unsigned ADDR_W = $clog2(PEXILS);   // pixel store address width

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver: 2-flop synchronizer, framing FSM and tick
// counter. Emits a one-cycle byte_valid_o in the stop-bit sample cycle and a
// registered one-cycle frame_err_o for a bad stop bit.
// Optional macro RX_PARITY_EN: expect an even-parity bit between bit 7 and stop.
module uart_rx_byte
  import img_pkg::*;
#(
  parameter int unsigned TICK_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned TickW = $clog2(TICK_PER_BIT);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_PER_BIT - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(TICK_PER_BIT / 2 - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Framing state, tick/bit counters and shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state logic: start bit checked at half a bit, later bits one bit apart.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    byte_valid_o = 1'b0;
`ifdef RX_PARITY_EN
    par_err_d    = par_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick_q == TickHalf) begin
          tick_d = '0;
          bit_d  = '0;
          // A line already high again was a glitch, not a start bit.
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (tick_q == TickLast) begin
          tick_d    = '0;
          par_err_d = rx_s_q ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          state_d = StIdle;
`ifdef RX_PARITY_EN
          // Bad parity and bad stop together still give a single error pulse.
          if (rx_s_q && !par_err_q) byte_valid_o = 1'b1;
          else                      frame_err_d  = 1'b1;
`else
          if (rx_s_q) byte_valid_o = 1'b1;
          else        frame_err_d  = 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign byte_data_o = shift_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_rx_loader.sv
// Image loader: wraps uart_rx_byte, packs BPP bytes MSB-first into a pixel,
// strobes it into the pixel store at a linear address and flags load_done_o
// once the last pixel of the frame is written.
// Optional macro RX_PARITY_EN (handled in uart_rx_byte): even-parity framing.
// BPP must be at least 2.
module uart_rx_loader #(
  parameter int unsigned TICK_PER_BIT = 434,
  parameter int unsigned BPP          = img_pkg::BPP,
  parameter int unsigned HIEGHT       = img_pkg::HIEGHT,
  parameter int unsigned WIDTH        = img_pkg::WIDTH,
  localparam int unsigned PEXILS      = HIEGHT * WIDTH,
  localparam int unsigned SZ          = 8 * BPP,
  localparam int unsigned AW          = $clog2(PEXILS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [SZ-1:0] wr_data_o,
  output logic          busy_o,
  output logic          frame_err_o,
  output logic          load_done_o
);

  localparam int unsigned CntW = $clog2(BPP);
  localparam logic [CntW-1:0] CntLast  = CntW'(BPP - 1);
  localparam logic [AW-1:0]   AddrLast = AW'(PEXILS - 1);

  logic       byte_valid;
  logic [7:0] byte_data;

  // Leading bytes of the pixel in progress; the final byte joins at write time.
  logic [SZ-9:0]   pix_q, pix_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [SZ-1:0]   wr_data_q, wr_data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            done_q, done_d;

  uart_rx_byte #(
    .TICK_PER_BIT(TICK_PER_BIT)
  ) u_rx_byte (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .frame_err_o (frame_err_o)
  );

  // Assembler and address counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  // Byte packing, write strobe, address advance and end-of-frame latch.
  always_comb begin
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    done_d    = done_q;

    if (byte_valid) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        pix_d = '0;
        // Once the frame is complete, bytes are still parsed but never written.
        if (!done_q) begin
          wr_en_d   = 1'b1;
          wr_data_d = {pix_q, byte_data};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        pix_d = (pix_q << 8) | (SZ - 8)'(byte_data);
      end
    end

    if (wr_en_q) begin
      if (addr_q == AddrLast) done_d = 1'b1;
      else                    addr_d = addr_q + 1'b1;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = wr_data_q;
  assign load_done_o = done_q;
  assign busy_o      = ((cnt_q != '0) || (addr_q != '0)) && !done_q;

endmodule
